// File: rtl/ao311_sweep_ctrl_pkg.sv
// rtl/ao311_sweep_ctrl_pkg.sv - shared types and widths for the AO311 sweep controller
package ao311_sweep_ctrl_pkg;

  localparam int VEC_W  = 5;
  localparam int ERR_W  = 6;
  localparam int WAIT_W = 4;
  localparam logic [VEC_W-1:0] VEC_LAST = 5'd31;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_CHECK  = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

endpackage

// File: rtl/ao311_sweep_ctrl_if.sv
// rtl/ao311_sweep_ctrl_if.sv - control, stimulus and status bundle of the sweep controller
interface ao311_sweep_ctrl_if;
  import ao311_sweep_ctrl_pkg::*;

  logic             start;
  logic             abort;
  logic             a, b, c, d, e;
  logic             z_rtl;
  logic             z;
  logic             busy;
  logic             done;
  logic             pass;
  logic [ERR_W-1:0] err_rtl;
  logic [ERR_W-1:0] err_gate;
  logic [VEC_W-1:0] first_fail_vec;
  logic             first_fail_vld;

  // master: the environment holding the two cell instances and issuing commands
  modport master (
    output start, abort, z_rtl, z,
    input  a, b, c, d, e, busy, done, pass, err_rtl, err_gate, first_fail_vec, first_fail_vld
  );

  modport slave (
    input  start, abort, z_rtl, z,
    output a, b, c, d, e, busy, done, pass, err_rtl, err_gate, first_fail_vec, first_fail_vld
  );

endinterface

// File: rtl/ao311_sweep_ctrl_golden.sv
// rtl/ao311_sweep_ctrl_golden.sv - reference AO311 function, z = (a & b & c) | d | e
module ao311_sweep_ctrl_golden
  import ao311_sweep_ctrl_pkg::*;
(
  input  logic [VEC_W-1:0] vec,
  output logic             exp
);

  assign exp = (vec[4] & vec[3] & vec[2]) | vec[1] | vec[0];

endmodule

// File: rtl/ao311_sweep_ctrl.sv
// rtl/ao311_sweep_ctrl.sv - steps a..e through all 32 vectors and counts RTL/gate mismatches
module ao311_sweep_ctrl
  import ao311_sweep_ctrl_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2
)(
  input  logic            clk,
  input  logic            reset,
  ao311_sweep_ctrl_if.slave bus
);

  localparam logic [WAIT_W-1:0] LAST_WAIT = WAIT_W'(SETTLE_CYCLES - 1);

  state_t           state;
  logic [VEC_W-1:0] vec;
  logic [VEC_W-1:0] stim;
  logic [WAIT_W-1:0] wait_cnt;
  logic             busy_q;
  logic             done_q;
  logic             pass_q;
  logic [ERR_W-1:0] err_rtl_q;
  logic [ERR_W-1:0] err_gate_q;
  logic [VEC_W-1:0] ff_vec_q;
  logic             ff_vld_q;
  logic             exp_z;
  logic             mis_rtl;
  logic             mis_gate;

  ao311_sweep_ctrl_golden u_golden (
    .vec (vec),
    .exp (exp_z)
  );

  // case inequality so an unknown cell output is reported as a mismatch
  assign mis_rtl  = (bus.z_rtl !== exp_z);
  assign mis_gate = (bus.z     !== exp_z);

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= ST_IDLE;
      vec        <= '0;
      stim       <= '0;
      wait_cnt   <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      err_rtl_q  <= '0;
      err_gate_q <= '0;
      ff_vec_q   <= '0;
      ff_vld_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.start && !bus.abort) begin
            vec        <= '0;
            wait_cnt   <= '0;
            err_rtl_q  <= '0;
            err_gate_q <= '0;
            pass_q     <= 1'b0;
            ff_vec_q   <= '0;
            ff_vld_q   <= 1'b0;
            busy_q     <= 1'b1;
            state      <= ST_SETTLE;
          end
        end
        ST_SETTLE: begin
          if (bus.abort) begin
            busy_q <= 1'b0;
            pass_q <= 1'b0;
            state  <= ST_IDLE;
          end else begin
            stim     <= vec;
            wait_cnt <= wait_cnt + 1'b1;
            if (wait_cnt == LAST_WAIT) state <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (bus.abort) begin
            busy_q <= 1'b0;
            pass_q <= 1'b0;
            state  <= ST_IDLE;
          end else begin
            if (mis_rtl)  err_rtl_q  <= err_rtl_q + 1'b1;
            if (mis_gate) err_gate_q <= err_gate_q + 1'b1;
            if ((mis_rtl || mis_gate) && !ff_vld_q) begin
              ff_vec_q <= vec;
              ff_vld_q <= 1'b1;
            end
            // 31 is terminal: the vector counter never wraps back to 0
            if (vec == VEC_LAST) begin
              busy_q <= 1'b0;
              done_q <= 1'b1;
              state  <= ST_DONE;
            end else begin
              vec      <= vec + 1'b1;
              wait_cnt <= '0;
              state    <= ST_SETTLE;
            end
          end
        end
        ST_DONE: begin
          pass_q <= (err_rtl_q == '0) && (err_gate_q == '0);
          state  <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign {bus.a, bus.b, bus.c, bus.d, bus.e} = stim;
  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
  assign bus.pass           = pass_q;
  assign bus.err_rtl        = err_rtl_q;
  assign bus.err_gate       = err_gate_q;
  assign bus.first_fail_vec = ff_vec_q;
  assign bus.first_fail_vld = ff_vld_q;

endmodule
